// File: rtl/sram_serial_loader_pkg.sv
// Shared definitions for the SRAM serial loader: FSM state encodings and the
// derived frame/counter widths used by the top level and its shift register.
// No ports; imported with sram_serial_loader_pkg::*.
package sram_serial_loader_pkg;

  // Loader FSM encodings (2 bits).
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SHIFT    = 2'd1;
  localparam logic [1:0] ST_WAIT_RDY = 2'd2;
  localparam logic [1:0] ST_GAP      = 2'd3;

  localparam int WORD_CNT_W = 16;

  // Frame length: address bits sit above the data bits.
  function automatic int reg_bits_width(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  // Width of a counter that must hold the values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sram_serial_loader_piso_shift_reg.sv
// Parallel-in / serial-out shift register; bit 0 is presented on so.
// Latency: so reflects the loaded word's bit 0 the cycle after load.
// Backpressure: none; load has priority over shift. WIDTH must be >= 2.
// Ports: clk, rst (sync, active-high), load/load_dat parallel load,
//        shift (shift right by one), so (current LSB).
module piso_shift_reg #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_dat,
  input  logic             shift,
  output logic             so
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_dat;
    end else if (shift) begin
      sr_d = {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign so = sr_q[0];

endmodule

// File: rtl/sram_serial_loader.sv
// Serializes {addr, data} host words LSB-first onto SO with BGN framing for
// SRAM_IO_CTRL, waits for RDY, then holds BGN low for GAP_CYCLES.
// Latency: SO = frame[0] the cycle after acceptance; min word period is
//          REG_BITS_WIDTH + 1 + GAP_CYCLES cycles.
// Backpressure: WR_READY only in IDLE and the last GAP cycle; words offered
//          at other times are held by the host.
// Ports: CLK/RST (sync, active-high); WR_VALID/WR_READY/WR_ADDR/WR_DATA host
//        side; RDY in, BGN/SO/LOAD_N out to SRAM_IO_CTRL; BUSY, DONE,
//        WORD_CNT, ERR status.
// Optional feature: define LOADER_TIMEOUT_EN to bound WAIT_RDY at
//        TIMEOUT_CYCLES cycles and raise the sticky ERR flag on expiry.
module sram_serial_loader
  import sram_serial_loader_pkg::*;
#(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 9,
  parameter int GAP_CYCLES        = 1,
  parameter int TIMEOUT_CYCLES    = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         WR_VALID,
  output logic                         WR_READY,
  input  logic [MEMORY_ADDR_WIDTH-1:0] WR_ADDR,
  input  logic [MEMORY_DATA_WIDTH-1:0] WR_DATA,
  input  logic                         RDY,
  output logic                         BGN,
  output logic                         SO,
  output logic                         LOAD_N,
  output logic                         BUSY,
  output logic                         DONE,
  output logic [WORD_CNT_W-1:0]        WORD_CNT,
  output logic                         ERR
);

  localparam int REG_BITS_WIDTH = reg_bits_width(MEMORY_ADDR_WIDTH, MEMORY_DATA_WIDTH);
  localparam int BIT_CNT_W      = cnt_width(REG_BITS_WIDTH);
  localparam int GAP_CNT_W      = cnt_width(GAP_CYCLES);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(REG_BITS_WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_CYCLES - 1);

  logic [1:0]            state_q,    state_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
  logic [GAP_CNT_W-1:0]  gap_cnt_q,  gap_cnt_d;
  logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic                  done_q,     done_d;
  logic                  load_n_q,   load_n_d;
  // Holds WR_READY low until the first clock after reset is released.
  logic                  rst_done_q, rst_done_d;

  logic gap_last;
  logic accept;
  logic rdy_ack;
  logic timeout;
  logic sr_so;

  assign gap_last = (state_q == ST_GAP) && (gap_cnt_q == GAP_LAST);
  assign WR_READY = rst_done_q && ((state_q == ST_IDLE) || gap_last);
  assign accept   = WR_VALID && WR_READY;
  assign rdy_ack  = (state_q == ST_WAIT_RDY) && RDY;

`ifdef LOADER_TIMEOUT_EN
  localparam int TO_CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic                err_q,    err_d;

  // RDY wins over expiry when both land on the final WAIT_RDY cycle.
  assign timeout = (state_q == ST_WAIT_RDY) && !RDY && (to_cnt_q == TO_LAST);

  always_comb begin
    to_cnt_d = to_cnt_q;
    err_d    = err_q | timeout;
    // Held at zero through SHIFT so every WAIT_RDY starts from a clean count.
    if (state_q == ST_SHIFT) begin
      to_cnt_d = '0;
    end else if (state_q == ST_WAIT_RDY) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign ERR = err_q;
`else
  assign timeout = 1'b0;
  // Tied low; the comparison is never true for a legal limit and keeps the
  // timeout parameter referenced when the feature is compiled out.
  assign ERR = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    word_cnt_d = word_cnt_q;
    done_d     = 1'b0;
    load_n_d   = load_n_q;
    rst_done_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
          load_n_d  = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q == BIT_LAST) begin
          state_d = ST_WAIT_RDY;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_WAIT_RDY: begin
        if (rdy_ack) begin
          state_d    = ST_GAP;
          gap_cnt_d  = '0;
          word_cnt_d = word_cnt_q + 1'b1;
          done_d     = 1'b1;
        end else if (timeout) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end
      end
      ST_GAP: begin
        if (gap_last) begin
          if (accept) begin
            // Back-to-back word: LOAD_N stays low.
            state_d   = ST_SHIFT;
            bit_cnt_d = '0;
          end else begin
            state_d  = ST_IDLE;
            load_n_d = 1'b1;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      word_cnt_q <= '0;
      done_q     <= 1'b0;
      load_n_q   <= 1'b1;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      word_cnt_q <= word_cnt_d;
      done_q     <= done_d;
      load_n_q   <= load_n_d;
      rst_done_q <= rst_done_d;
    end
  end

  piso_shift_reg #(
    .WIDTH (REG_BITS_WIDTH)
  ) u_piso (
    .clk      (CLK),
    .rst      (RST),
    .load     (accept),
    .load_dat ({WR_ADDR, WR_DATA}),
    .shift    (state_q == ST_SHIFT),
    .so       (sr_so)
  );

  assign BGN      = (state_q == ST_SHIFT) || (state_q == ST_WAIT_RDY);
  assign SO       = (state_q == ST_SHIFT) && sr_so;
  assign BUSY     = (state_q != ST_IDLE);
  assign DONE     = done_q;
  assign LOAD_N   = load_n_q;
  assign WORD_CNT = word_cnt_q;

endmodule

// File: tb/tb_sram_serial_loader.sv
// Bench for sram_serial_loader: the stimulus side pushes each accepted
// {addr, data} frame into a queue; a downstream process behaves as the
// SRAM_IO_CTRL end, assembles SO bits while BGN is high, returns RDY and
// compares frames, DONE and WORD_CNT. Define LOADER_TIMEOUT_EN to add the
// timeout scenario.
module tb_sram_serial_loader;

  localparam int AW  = 9;
  localparam int DW  = 8;
  localparam int RB  = AW + DW;
  localparam int GAP = 1;
  localparam int TO  = 32;

  logic          CLK = 1'b0;
  logic          RST;
  logic          WR_VALID;
  logic          WR_READY;
  logic [AW-1:0] WR_ADDR;
  logic [DW-1:0] WR_DATA;
  logic          RDY;
  logic          BGN, SO, LOAD_N, BUSY, DONE, ERR;
  logic [15:0]   WORD_CNT;

  sram_serial_loader #(
    .MEMORY_DATA_WIDTH (DW),
    .MEMORY_ADDR_WIDTH (AW),
    .GAP_CYCLES        (GAP),
    .TIMEOUT_CYCLES    (TO)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .WR_VALID (WR_VALID),
    .WR_READY (WR_READY),
    .WR_ADDR  (WR_ADDR),
    .WR_DATA  (WR_DATA),
    .RDY      (RDY),
    .BGN      (BGN),
    .SO       (SO),
    .LOAD_N   (LOAD_N),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .WORD_CNT (WORD_CNT),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [RB-1:0] exp_q[$];
  int          rdy_delay  = 1;   // WAIT_RDY cycles before RDY; 0 = never
  bit          rand_delay = 0;
  bit          rdy_noise  = 0;   // toggle RDY randomly while shifting
  bit          burst_active = 0;
  int          exp_acks  = 0;
  int          done_seen = 0;
  int          frames_rx = 0;
  logic [15:0] exp_cnt;
  logic [RB-1:0] last_frame;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input int val);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: observed %0d", name, val);
  endtask

  // Downstream end: frame capture, RDY handshake and scoreboard compare.
  initial begin : monitor
    int rx_cnt, wait_cnt, cur_delay;
    bit pending;
    logic [RB-1:0] rx;
    rx_cnt = 0; wait_cnt = 0; cur_delay = 1; pending = 0; rx = '0; RDY = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        rx_cnt = 0; wait_cnt = 0; pending = 0; RDY = 1'b0; exp_cnt = 16'h0;
      end else begin
        if (DONE) done_seen++;
        if (BGN) check("ready_low_in_frame", WR_READY, 0);
        if (burst_active) check("load_n_burst", LOAD_N, 0);
        if (pending) begin
          check("bgn_after_rdy", BGN, 0);
          check("done_after_rdy", DONE, 1);
          check("word_cnt", WORD_CNT, exp_cnt);
          pending = 0; rx_cnt = 0; RDY = 1'b0;
        end else if (BGN && rx_cnt < RB) begin
          rx[rx_cnt] = SO;
          rx_cnt++;
          RDY = rdy_noise ? 1'($urandom_range(0, 1)) : 1'b0;
          if (rx_cnt == RB) begin
            frames_rx++;
            last_frame = rx;
            wait_cnt   = 0;
            cur_delay  = rand_delay ? int'($urandom_range(1, 4)) : rdy_delay;
            if (exp_q.size() == 0) fail_now("frame_unexpected", int'(rx));
            else check("frame", rx, exp_q.pop_front());
          end
        end else if (BGN) begin
          wait_cnt++;
          check("so_in_wait", SO, 0);
          if (cur_delay != 0 && wait_cnt == cur_delay) begin
            RDY = 1'b1; pending = 1; exp_cnt++; exp_acks++;
          end else begin
            RDY = 1'b0;
          end
        end else if (rx_cnt == RB) begin
`ifdef LOADER_TIMEOUT_EN
          check("timeout_len", wait_cnt, TO);
          check("err_on_timeout", ERR, 1);
          check("no_done_on_timeout", DONE, 0);
          check("cnt_on_timeout", WORD_CNT, exp_cnt);
`else
          fail_now("wait_left_without_rdy", wait_cnt);
`endif
          rx_cnt = 0; RDY = 1'b0;
        end else if (rx_cnt != 0) begin
          fail_now("frame_cut_bits", rx_cnt);
          rx_cnt = 0;
        end else begin
          RDY = 1'b0;
        end
      end
    end
  end

  // Offer a word (called at a negedge); returns the cycle of acceptance.
  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, output int t_acc);
    t_acc = -1;
    WR_VALID = 1'b1; WR_ADDR = a; WR_DATA = d;
    for (int i = 0; i < 300 && t_acc < 0; i++) begin
      if (WR_READY) begin
        exp_q.push_back({a, d});
        t_acc = cyc;
      end
      @(negedge CLK);
    end
    WR_VALID = 1'b0;
    if (t_acc < 0) fail_now("accept_timeout", 300);
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((BUSY || exp_q.size() != 0) && i < 500) begin
      @(negedge CLK);
      i++;
    end
    if (i >= 500) fail_now("idle_timeout", i);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    #1 RST = 1'b1;
    exp_q.delete();
    @(negedge CLK);
    @(negedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t, t_prev;
    int so_seq[RB] = '{1,1,0,1,0,0,1,0, 0,0,0,0,0,1,0,0,0};
    logic [RB-1:0] seq;
    RST = 1'b1; WR_VALID = 1'b0; WR_ADDR = '0; WR_DATA = '0;
    repeat (3) @(negedge CLK);

    // Reset state
    check("rst_bgn", BGN, 0);
    check("rst_so", SO, 0);
    check("rst_load_n", LOAD_N, 1);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_word_cnt", WORD_CNT, 0);
    check("rst_err", ERR, 0);
    check("rst_wr_ready", WR_READY, 0);
    #1 RST = 1'b0;
    #1 check("ready_before_edge", WR_READY, 0);
    @(negedge CLK);
    check("ready_after_release", WR_READY, 1);

    // Single word 0x020 / 0x4B, RDY two cycles into WAIT_RDY
    rdy_delay = 2;
    send(9'h020, 8'h4B, t);
    wait_idle();
    for (int k = 0; k < RB; k++) seq[k] = so_seq[k][0];
    check("first_so_sequence", last_frame, seq);
    check("first_done_count", done_seen, 1);
    check("first_word_cnt", WORD_CNT, 1);
    check("first_load_n", LOAD_N, 1);

    // 14 back-to-back words, WR_VALID held through each frame
    do_reset();
    rdy_delay = 1;
    t_prev = 0;
    for (int i = 0; i < 14; i++) begin
      send(AW'(32 + i), DW'($urandom), t);
      if (i == 0) burst_active = 1;
      else check("b2b_spacing", t - t_prev, RB + rdy_delay + GAP);
      t_prev = t;
      WR_VALID = 1'b1;  // keep offering during the next frame
    end
    WR_VALID = 1'b0;
    burst_active = 0;
    wait_idle();
    check("burst_word_cnt", WORD_CNT, 14);
    check("burst_load_n_end", LOAD_N, 1);
    check("burst_frames", frames_rx, 15);

    // Random traffic, random RDY latency, RDY noise while shifting
    rand_delay = 1; rdy_noise = 1;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      send(AW'($urandom), DW'($urandom), t);
    end
    wait_idle();
    check("rand_word_cnt", WORD_CNT, exp_cnt);
    rand_delay = 0; rdy_noise = 0;

    // Reset while bit 8 is on SO
    send(AW'($urandom), DW'($urandom), t);
    repeat (8) @(posedge CLK);
    @(negedge CLK);
    #1 RST = 1'b1;
    exp_q.delete();
    @(negedge CLK);
    check("midrst_bgn", BGN, 0);
    check("midrst_so", SO, 0);
    check("midrst_load_n", LOAD_N, 1);
    check("midrst_word_cnt", WORD_CNT, 0);
    check("midrst_busy", BUSY, 0);
    check("midrst_wr_ready", WR_READY, 0);
    #1 RST = 1'b0;
    @(negedge CLK);
    send(AW'($urandom), DW'($urandom), t);
    wait_idle();
    check("post_rst_word_cnt", WORD_CNT, 1);

    // WORD_CNT wrap from 16'hFFFF
    exp_cnt = 16'hFFFF;
    force dut.word_cnt_q = 16'hFFFF;
    @(negedge CLK);
    release dut.word_cnt_q;
    @(negedge CLK);
    check("preload_word_cnt", WORD_CNT, 16'hFFFF);
    send(AW'($urandom), DW'($urandom), t);
    wait_idle();
    check("wrap_word_cnt", WORD_CNT, 0);

`ifdef LOADER_TIMEOUT_EN
    rdy_delay = 0;
    send(AW'($urandom), DW'($urandom), t);
    wait_idle();
    check("err_sticky", ERR, 1);
    rdy_delay = 1;
    send(AW'($urandom), DW'($urandom), t);
    wait_idle();
    check("err_after_next", ERR, 1);
    check("cnt_after_timeout", WORD_CNT, 1);
`else
    check("err_tied_low", ERR, 0);
`endif

    check("done_total", done_seen, exp_acks);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
